// File: rtl/tt_um_jimktrains_vslc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tt_um_jimktrains_vslc_scan_sequencer
// Desc   : PLC scan controller; replays a byte-loaded program once per scan.
// Rev    : 1.0  initial release
// ============================================================================
module tt_um_jimktrains_vslc_scan_sequencer #(
    parameter int PROG_DEPTH = 32,
    parameter int ADDR_W     = 5,
    parameter int READY_HIGH = 1,
    parameter int READY_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              load_en,
    input  logic              load_strobe,
    input  logic [7:0]        load_data,
    input  logic [3:0]        scan_div,
    input  logic [7:0]        ui_in,
    output logic [15:0]       counter,
    output logic [7:0]        instr,
    output logic              instr_ready,
    output logic [7:0]        ui_in_scan,
    output logic [7:0]        ui_in_prev,
    output logic              busy,
    output logic              scan_done,
    output logic [ADDR_W:0]   prog_len,
    output logic              load_err,
    output logic              overrun
);
    localparam int PH_MAX = (READY_HIGH > READY_LOW) ? READY_HIGH : READY_LOW;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0]  C_HIGH_LAST = PH_W'(READY_HIGH - 1);
    localparam logic [PH_W-1:0]  C_LOW_LAST  = PH_W'(READY_LOW - 1);
    localparam logic [ADDR_W:0]  C_DEPTH     = (ADDR_W + 1)'(PROG_DEPTH);
    localparam logic [ADDR_W:0]  C_ONE_W     = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_TICK, S_PRESENT, S_GAP, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         counter_q;
    logic                tbit_q;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W:0]     wptr_q, wptr_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [7:0]          instr_q, instr_d;
    logic [7:0]          scan_q, scan_d;
    logic [7:0]          prev_q, prev_d;
    logic                load_err_q, load_err_d;
    logic                overrun_q, overrun_d;

    logic [7:0]          mem [PROG_DEPTH];
    logic                w_wr;
    logic [3:0]          w_sel;
    logic                w_tick;
    logic                w_last;
    logic [ADDR_W-1:0]   w_pc_inc;

    assign w_sel    = scan_div - 4'd1;
    // Tick is a rising edge of the selected counter bit, seen against last cycle's copy.
    assign w_tick   = (scan_div == 4'd0) ? 1'b1 : (counter_q[w_sel] & ~tbit_q);
    assign w_last   = ({1'b0, pc_q} == (wptr_q - C_ONE_W));
    assign w_pc_inc = pc_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wptr_d     = wptr_q;
        ph_d       = ph_q;
        instr_d    = instr_q;
        scan_d     = scan_q;
        prev_d     = prev_q;
        load_err_d = load_err_q;
        overrun_d  = overrun_q;
        w_wr       = 1'b0;

        if (w_tick && (state_q == S_PRESENT || state_q == S_GAP || state_q == S_DONE))
            overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    state_d    = S_LOAD;
                    wptr_d     = '0;
                    load_err_d = 1'b0;
                    overrun_d  = 1'b0;
                end else if (run && (wptr_q != '0)) begin
                    state_d = S_WAIT_TICK;
                end
            end
            S_LOAD: begin
                if (!load_en) begin
                    state_d = S_IDLE;
                end else if (load_strobe) begin
                    if (wptr_q < C_DEPTH) begin
                        w_wr   = 1'b1;
                        wptr_d = wptr_q + C_ONE_W;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            S_WAIT_TICK: begin
                // Abandoning the wait wins over a coincident tick.
                if (!run || load_en) begin
                    state_d = S_IDLE;
                end else if (w_tick) begin
                    state_d = S_PRESENT;
                    pc_d    = '0;
                    ph_d    = '0;
                    instr_d = mem['0];
                    prev_d  = scan_q;
                    scan_d  = ui_in;
                end
            end
            S_PRESENT: begin
                if (ph_q == C_HIGH_LAST) begin
                    ph_d    = '0;
                    state_d = S_GAP;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_GAP: begin
                if (ph_q == C_LOW_LAST) begin
                    ph_d = '0;
                    if (w_last) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = w_pc_inc;
                        instr_d = mem[w_pc_inc];
                        state_d = S_PRESENT;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_DONE: begin
                if (load_en)  state_d = S_IDLE;
                else if (run) state_d = S_WAIT_TICK;
                else          state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            counter_q  <= '0;
            tbit_q     <= 1'b0;
            pc_q       <= '0;
            wptr_q     <= '0;
            ph_q       <= '0;
            instr_q    <= '0;
            scan_q     <= '0;
            prev_q     <= '0;
            load_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_q + 16'd1;
            tbit_q     <= counter_q[w_sel];
            pc_q       <= pc_d;
            wptr_q     <= wptr_d;
            ph_q       <= ph_d;
            instr_q    <= instr_d;
            scan_q     <= scan_d;
            prev_q     <= prev_d;
            load_err_q <= load_err_d;
            overrun_q  <= overrun_d;
        end
    end

    // Program store carries no reset; prog_len gates what is ever read.
    always_ff @(posedge clk) begin
        if (w_wr) mem[wptr_q[ADDR_W-1:0]] <= load_data;
    end

    assign counter     = counter_q;
    assign instr       = instr_q;
    assign instr_ready = (state_q == S_PRESENT);
    assign busy        = (state_q == S_PRESENT) || (state_q == S_GAP);
    assign scan_done   = (state_q == S_DONE);
    assign ui_in_scan  = scan_q;
    assign ui_in_prev  = prev_q;
    assign prog_len    = wptr_q;
    assign load_err    = load_err_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire
